// File: rtl/vga_sync.sv
// vga_sync: VGA timing generator. A clock divider produces a one-clk pixel
// enable (p_tick); the horizontal and vertical counters advance on it, and the
// sync outputs are registered from the counters' next values.
//
// Ports:
//   clk        in   system clock, all logic on rising edge
//   rstn       in   asynchronous reset, ACTIVE-HIGH despite the name (1 = reset)
//   hsync      out  horizontal sync, active-low, registered
//   vsync      out  vertical sync, active-low, registered
//   video_on   out  high while (pixel_x, pixel_y) lies in the visible area
//   p_tick     out  one-clk pixel enable, high one clk in every CLK_DIV
//   pixel_x    out  raw horizontal counter, 0..H_TOTAL-1
//   pixel_y    out  raw vertical counter, 0..V_TOTAL-1
//   frame_tick out  one-clk pulse on the p_tick that wraps (H_TOTAL-1, V_TOTAL-1)
//                   to (0,0); only generated with VGA_SYNC_FRAME_TICK_EN defined,
//                   otherwise tied to 0.
//
// Optional feature macro: VGA_SYNC_FRAME_TICK_EN
// CLK_DIV legal range is 2..16 (div_cnt is 4 bits, and p_tick must be low
// while the divider sits at 0 during reset).

module vga_sync #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 4
) (
  input  logic       clk,
  input  logic       rstn,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START   = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START   = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic [3:0] DIV_MAX    = 4'(CLK_DIV - 1);

  logic [3:0] div_cnt_q, div_cnt_d;
  logic [9:0] pixel_x_q, pixel_x_d;
  logic [9:0] pixel_y_q, pixel_y_d;
  logic       hsync_q,   hsync_d;
  logic       vsync_q,   vsync_d;

  logic       tick;
  logic       x_wrap;
  logic       y_wrap;

  // Pixel enable is decoded from the registered divider, so it is glitch-free
  // and low during reset (div_cnt = 0 and CLK_DIV >= 2). The divider starts at
  // 0 on release, so the first tick lands on the CLK_DIV-th edge.
  assign tick   = (div_cnt_q == DIV_MAX);
  assign x_wrap = (pixel_x_q == H_MAX);
  assign y_wrap = (pixel_y_q == V_MAX);

  always_comb begin
    div_cnt_d = tick ? 4'd0 : div_cnt_q + 4'd1;
    pixel_x_d = pixel_x_q;
    pixel_y_d = pixel_y_q;

    if (tick) begin
      pixel_x_d = x_wrap ? 10'd0 : pixel_x_q + 10'd1;
      if (x_wrap) begin
        pixel_y_d = y_wrap ? 10'd0 : pixel_y_q + 10'd1;
      end
    end

    // Syncs decode the next count so the registered sync flips on the same
    // edge as the counters: zero pixel skew, no combinational glitches.
    hsync_d = ~((pixel_x_d >= HS_START) && (pixel_x_d <= HS_END));
    vsync_d = ~((pixel_y_d >= VS_START) && (pixel_y_d <= VS_END));
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      div_cnt_q <= 4'd0;
      pixel_x_q <= 10'd0;
      pixel_y_q <= 10'd0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
    end else begin
      div_cnt_q <= div_cnt_d;
      pixel_x_q <= pixel_x_d;
      pixel_y_q <= pixel_y_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
    end
  end

  assign p_tick   = tick;
  assign pixel_x  = pixel_x_q;
  assign pixel_y  = pixel_y_q;
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  // Counters are stable for the whole pixel period, so this is too.
  assign video_on = (pixel_x_q < H_VIS) && (pixel_y_q < V_VIS);

`ifdef VGA_SYNC_FRAME_TICK_EN
  // High in the single clk whose edge wraps the raster back to (0,0).
  assign frame_tick = tick && x_wrap && y_wrap;
`else
  assign frame_tick = 1'b0;
`endif

endmodule

// File: doc/vga_sync.md
VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 SHALL have parameter H_DISPLAY, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-004 SHALL have parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_DISPLAY, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-008 SHALL have parameter V_BACK, default 33, vertical back porch in lines.
REQ-009 SHALL have parameter CLK_DIV, default 4, clk cycles per pixel (legal range 2..16).
REQ-010 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-011 SHALL have port rstn, input, 1 bit: reset, asynchronous, active-high (1 = reset asserted).
REQ-012 SHALL have port hsync, output, 1 bit: horizontal sync, active-low, registered.
REQ-013 SHALL have port vsync, output, 1 bit: vertical sync, active-low, registered.
REQ-014 SHALL have port video_on, output, 1 bit: high while the pixel counters lie inside the visible area.
REQ-015 SHALL have port p_tick, output, 1 bit: one-clk pixel-enable pulse.
REQ-016 SHALL have port pixel_x, output, 10 bits: raw horizontal counter, 0..H_TOTAL-1.
REQ-017 SHALL have port pixel_y, output, 10 bits: raw vertical counter, 0..V_TOTAL-1.
REQ-018 SHALL have port frame_tick, output, 1 bit: one-clk pulse at frame wrap (see Configuration).

Function
REQ-019 SHALL derive H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800) and V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
REQ-020 SHALL run a divider counter div_cnt, 0..CLK_DIV-1, incrementing every clk and wrapping to 0.
REQ-021 SHALL assert p_tick combinationally from registered state whenever div_cnt == CLK_DIV-1: exactly one clk high out of every CLK_DIV.
REQ-022 SHALL advance pixel_x only on clk edges where p_tick is 1: increment, or wrap from H_TOTAL-1 to 0.
REQ-023 SHALL advance pixel_y only on a p_tick edge where pixel_x wraps: increment, or wrap from V_TOTAL-1 to 0.
REQ-024 SHALL hold pixel_x and pixel_y unchanged on clk edges where p_tick is 0.
REQ-025 SHALL drive hsync to 0 exactly while pixel_x is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] (656..751), else 1.
REQ-026 SHALL drive vsync to 0 exactly while pixel_y is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] (490..491), else 1.
REQ-027 SHALL register hsync and vsync from the next-count values, so they change on the same edge as the counters, with zero pixel skew and no glitches.
REQ-028 SHALL drive video_on = (pixel_x < H_DISPLAY) && (pixel_y < V_DISPLAY), valid for the full pixel period.
REQ-029 SHALL keep pixel_x and pixel_y at 0 during reset and on the first clk after reset release, and SHALL NOT emit a partial-divider p_tick.

Reset
REQ-030 SHALL, while rstn = 1, asynchronously force div_cnt = 0, pixel_x = 0, pixel_y = 0, hsync = 1, vsync = 1, frame_tick = 0, p_tick = 0 (since CLK_DIV ≥ 2), and video_on = 1 (derived from counters at 0,0).
REQ-031 SHALL, on reset assertion mid-frame, abort the frame; after release, the first p_tick SHALL occur on the CLK_DIV-th clk edge and timing SHALL restart at (0,0).

Configuration
REQ-032 SHALL, with macro VGA_SYNC_FRAME_TICK_EN defined, assert frame_tick for exactly the one clk in which p_tick = 1 and pixel_x = H_TOTAL-1 and pixel_y = V_TOTAL-1 (the edge that wraps to 0,0).
REQ-033 SHALL, without VGA_SYNC_FRAME_TICK_EN, keep the frame_tick port and tie it constant 0, with no frame-detect logic generated.

Verification
REQ-034 SHALL check: reset released, defaults -> p_tick high on clk cycles 4, 8, 12, …; pixel_x reads 1 after the 4th edge.
REQ-035 SHALL check: run one line -> hsync low for exactly 96 p_ticks starting at pixel_x = 656; pixel_x wraps 799 -> 0 and pixel_y steps 0 -> 1.
REQ-036 SHALL check: run one frame -> vsync low for lines 490..491 only (2 × 800 p_ticks); pixel_y wraps 524 -> 0; frame period = 420000 p_ticks = 1680000 clks.
REQ-037 SHALL check: video_on high for (639,479), low for (640,0) and (0,480); count of video_on pixels per frame = 307200.
REQ-038 SHALL check: assert rstn at pixel (700,300), asynchronously between clk edges -> all outputs take reset values immediately; after release, timing restarts at (0,0).
REQ-039 SHALL check: with VGA_SYNC_FRAME_TICK_EN -> exactly one frame_tick per frame, coincident with the (799,524) p_tick; without the macro -> frame_tick stays 0 for 2 frames.
